lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store unit between the execute stage and the byte-addressed data memory (10-bit byte address, 32-bit little-endian word at addr..addr+3, registered read one cycle after en&&!rW, word write on en&&rW).
- Decodes RV32I LB/LH/LW/LBU/LHU/SB/SH/SW from funct3.
- Sub-word stores use read-modify-write.
- Loads are sign- or zero-extended; misaligned, out-of-range and illegal accesses are faulted without touching memory.
- Valid/ready request and response handshakes.

Parameters:
ADDR_W, 10, memory byte-address width; valid byte range 0..2^ADDR_W-1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address (rs1+imm)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  access rejected, no memory side effect
mem_addr  out  ADDR_W  memory byte address
mem_rW  out  1  1=write, 0=read
mem_en  out  1  memory enable
mem_dataIn  out  32  write word to memory
mem_dataOut  in  32  read word from memory

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_en=0, mem_rW=0, mem_addr=0, mem_dataIn=0. All internal latches cleared.
- mem_en, mem_rW and mem_addr decode from the state register only. If reset asserts mid-WRITE, mem_en drops immediately and no write occurs at the next edge. The transaction is lost and no response is produced.
- Accept: in IDLE, when req_valid && req_ready, latch we, funct3, addr[ADDR_W-1:0] and wdata.
- Fault check at accept; any of these sets fault:
  - loads: funct3 in {011,110,111}; stores: funct3 not in {000,001,010}
  - halfword with addr[0]=1; word with addr[1:0]!=0
  - addr[31:ADDR_W] nonzero
- Natural alignment guarantees addr+3 stays within range for valid word accesses.
- States:
  - IDLE: if fault -> RESP (fault=1). Else if SW -> WRITE. Else -> READ.
  - READ: mem_en=1, mem_rW=0, mem_addr=addr_q. -> CAPTURE.
  - CAPTURE: mem_dataOut holds bytes addr..addr+3; mem_en=0.
    - Load: byte = dataOut[7:0], half = dataOut[15:0], word = dataOut. LB/LH sign-extend, LBU/LHU zero-extend. Register into resp_rdata -> RESP.
    - SB: wbuf = {dataOut[31:8], wdata[7:0]}. SH: wbuf = {dataOut[31:16], wdata[15:0]}. -> WRITE.
  - WRITE: mem_en=1, mem_rW=1, mem_addr=addr_q, mem_dataIn = wbuf (SB/SH) or wdata_q (SW). -> RESP.
  - RESP: resp_valid=1; rdata/fault held stable. On resp_ready -> IDLE; resp_valid drops the next cycle.
- Latency, counted from the accept edge to first resp_valid cycle:
  - fault: 1
  - SW: 2
  - loads: 3
  - SB/SH: 4
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake, since req_ready is low outside IDLE.
- mem_dataIn = 0 whenever mem_rW = 0. Outside READ and WRITE, mem_addr holds addr_q.
- resp_ready arriving before resp_valid has no effect. req_* inputs are ignored outside IDLE.
- The unit never asserts mem_en while rst is high.

Test Plan:
- Memory word at 0x010 = 0x80FF7F01. LB 0x010 -> rdata 0x00000001. LB 0x013 -> 0xFFFFFF80. LBU 0x013 -> 0x00000080. Each arrives 3 cycles after accept.
- Same word: LH 0x012 -> 0xFFFF80FF; LHU 0x012 -> 0x000080FF; LW 0x010 -> 0x80FF7F01.
- SW 0xDEADBEEF @0x020 -> single write cycle, resp_valid 2 cycles after accept. Then SB 0x000000AA @0x021 -> read, merge, write. LW 0x020 returns 0xDEADAAEF. SB resp arrives 4 cycles after accept.
- Faults, each giving resp_fault=1, rdata=0, mem_en never high, response 1 cycle after accept:
  - LW @0x022
  - SH @0x031
  - LB @0x00000400
  - load funct3=011
- Hold resp_ready=0 for 5 cycles after an LW. resp_valid and rdata stay stable, req_ready stays 0, and a second req_valid is not accepted until 1 cycle after the handshake.
- Assert rst during the WRITE cycle of SH 0x1234 @0x040 (old word 0x11111111). mem_en falls immediately, no response is produced, and LW 0x040 after reset returns 0x11111111.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response handshake plus data-memory bus of the load/store unit.
`default_nettype none

interface lsu_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rW;
  logic              mem_en;
  logic [31:0]       mem_dataIn;
  logic [31:0]       mem_dataOut;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_dataOut,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_addr, mem_rW, mem_en, mem_dataIn
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_dataOut,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_addr, mem_rW, mem_en, mem_dataIn
  );
endinterface

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store unit with read-modify-write sub-word stores and
// fault rejection of misaligned, out-of-range and illegal accesses.
`default_nettype none

module lsu_ctrl #(
  parameter int ADDR_W = 10
) (
  input  wire logic   clk,
  input  wire logic   rst,
  lsu_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  logic              illegal_f3;
  logic              misaligned;
  logic              out_of_range;
  logic              req_fault;

  // Alignment uses funct3[1:0] (00 byte, 01 half, 10 word); illegal codes fault regardless.
  always_comb begin
    if (bus.req_we) begin
      illegal_f3 = !((bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                     (bus.req_funct3 == 3'b010));
    end else begin
      illegal_f3 = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
    end
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = |bus.req_addr[31:ADDR_W];
    req_fault    = illegal_f3 || misaligned || out_of_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      wbuf_q   <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wbuf_q   <= wbuf_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wbuf_d   = wbuf_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr[ADDR_W-1:0];
          wdata_d  = bus.req_wdata;
          wbuf_d   = '0;
          rdata_d  = '0;
          fault_d  = req_fault;
          if (req_fault) begin
            state_d = RESP;
          end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end

      READ: state_d = CAPTURE;

      CAPTURE: begin
        if (!we_q) begin
          case (funct3_q)
            3'b000:  rdata_d = {{24{bus.mem_dataOut[7]}}, bus.mem_dataOut[7:0]};
            3'b001:  rdata_d = {{16{bus.mem_dataOut[15]}}, bus.mem_dataOut[15:0]};
            3'b010:  rdata_d = bus.mem_dataOut;
            3'b100:  rdata_d = {24'h0, bus.mem_dataOut[7:0]};
            3'b101:  rdata_d = {16'h0, bus.mem_dataOut[15:0]};
            default: rdata_d = '0;
          endcase
          state_d = RESP;
        end else begin
          // Merge the new low byte/half over the bytes just read at the same address.
          if (funct3_q[0]) begin
            wbuf_d = {bus.mem_dataOut[31:16], wdata_q[15:0]};
          end else begin
            wbuf_d = {bus.mem_dataOut[31:8], wdata_q[7:0]};
          end
          state_d = WRITE;
        end
      end

      WRITE: state_d = RESP;

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Memory strobes come from the state register only, so an async reset drops them at once.
  assign bus.mem_en     = (state_q == READ) || (state_q == WRITE);
  assign bus.mem_rW     = (state_q == WRITE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_dataIn = (state_q != WRITE) ? 32'h0 :
                          (funct3_q == 3'b010) ? wdata_q : wbuf_q;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

endmodule

`default_nettype wire
